// File: rtl/nec_ir_pkg.sv
// nec_ir_pkg: shared types and default timing for the NEC IR transmitter.
// Holds the frame state enum, default clk25 cycle counts (25 MHz), the duration
// counter width and small helpers for loading and range-checking durations.
package nec_ir_pkg;

  localparam int CNT_W = 20;

  // Default cycle counts at 25 MHz.
  localparam int unsigned DEF_LEAD_MARK_CYC   = 225000;  // 9 ms
  localparam int unsigned DEF_LEAD_SPACE_CYC  = 112500;  // 4.5 ms
  localparam int unsigned DEF_BIT_MARK_CYC    = 14063;   // 562.5 us
  localparam int unsigned DEF_ZERO_SPACE_CYC  = 14063;
  localparam int unsigned DEF_ONE_SPACE_CYC   = 42188;   // 1687.5 us
  localparam int unsigned DEF_GAP_CYC         = 1000000; // 40 ms
  localparam int unsigned DEF_CARR_PERIOD_CYC = 658;     // ~38 kHz
  localparam int unsigned DEF_CARR_HIGH_CYC   = 219;     // ~1/3 duty

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } nec_state_e;

  // Down-counter value loaded on state entry so the state lasts exactly n cycles.
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

  // A duration must be non-zero and fit the duration counter.
  function automatic logic cyc_ok(input int unsigned n);
    return (n != 0) && (n < (32'd1 << CNT_W));
  endfunction

  function automatic logic is_mark(input nec_state_e s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/nec_ir_carrier.sv
// nec_ir_carrier: restartable ~38 kHz carrier for the mark states.
// Ports: clk25/rst (async, active-high); restart zeroes the phase for the next
// cycle; enable advances it; carrier is the value for the next cycle (caller registers it).
module nec_ir_carrier
  import nec_ir_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = DEF_CARR_PERIOD_CYC,
  parameter int unsigned HIGH_CYC   = DEF_CARR_HIGH_CYC
) (
  input  logic clk25,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic carrier
);

  localparam int CW = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CW'(PERIOD_CYC - 1)) cnt_d = '0;
      else                              cnt_d = cnt_q + CW'(1);
    end
  end

  // Decoded from the next phase so the registered output lines up with cnt_q.
  assign carrier = enable && (cnt_d < CW'(HIGH_CYC));

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nec_ir_tx.sv
// nec_ir_tx: serialises a 32-bit NEC command (bit 0 first) into leader, 32 bit
// slots, stop mark and 40 ms gap. Ports: clk25, rst (async, active-high), cmd/valid/
// ready accept (ready only in IDLE, no queueing), ir_output LED drive, frame_done
// pulse on the last gap cycle. All outputs registered; output follows the accept by one cycle.
// Build option NEC_IR_CARRIER_EN: defined -> marks carry the carrier; undefined -> raw envelope.
module nec_ir_tx
  import nec_ir_pkg::*;
#(
  parameter int unsigned LEAD_MARK_CYC   = DEF_LEAD_MARK_CYC,
  parameter int unsigned LEAD_SPACE_CYC  = DEF_LEAD_SPACE_CYC,
  parameter int unsigned BIT_MARK_CYC    = DEF_BIT_MARK_CYC,
  parameter int unsigned ZERO_SPACE_CYC  = DEF_ZERO_SPACE_CYC,
  parameter int unsigned ONE_SPACE_CYC   = DEF_ONE_SPACE_CYC,
  parameter int unsigned GAP_CYC         = DEF_GAP_CYC,
  parameter int unsigned CARR_PERIOD_CYC = DEF_CARR_PERIOD_CYC,
  parameter int unsigned CARR_HIGH_CYC   = DEF_CARR_HIGH_CYC
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic [31:0] cmd,
  input  logic        valid,
  output logic        ready,
  output logic        ir_output,
  output logic        frame_done
);

  if (!cyc_ok(LEAD_MARK_CYC) || !cyc_ok(LEAD_SPACE_CYC) || !cyc_ok(BIT_MARK_CYC) ||
      !cyc_ok(ZERO_SPACE_CYC) || !cyc_ok(ONE_SPACE_CYC) || !cyc_ok(GAP_CYC) ||
      (CARR_HIGH_CYC >= CARR_PERIOD_CYC)) begin : g_bad_cfg
    $error("nec_ir_tx: cycle parameter out of range");
  end

  nec_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [31:0]      shift_q, shift_d;
  logic             ready_q, ready_d;
  logic             ir_output_q, ir_output_d;
  logic             frame_done_q, frame_done_d;
  logic             mark_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (state_q == IDLE) begin
      if (valid && ready_q) begin
        state_d   = LEAD_MARK;
        cnt_d     = cyc_load(LEAD_MARK_CYC);
        shift_d   = cmd;
        bit_idx_d = '0;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      case (state_q)
        LEAD_MARK: begin
          state_d = LEAD_SPACE;
          cnt_d   = cyc_load(LEAD_SPACE_CYC);
        end
        LEAD_SPACE: begin
          state_d = BIT_MARK;
          cnt_d   = cyc_load(BIT_MARK_CYC);
        end
        BIT_MARK: begin
          // The space length encodes the bit currently at the bottom of the shifter.
          state_d = BIT_SPACE;
          cnt_d   = shift_q[0] ? cyc_load(ONE_SPACE_CYC) : cyc_load(ZERO_SPACE_CYC);
        end
        BIT_SPACE: begin
          cnt_d = cyc_load(BIT_MARK_CYC);
          if (bit_idx_q == 5'd31) begin
            state_d = STOP_MARK;
          end else begin
            state_d   = BIT_MARK;
            shift_d   = {1'b0, shift_q[31:1]};
            bit_idx_d = bit_idx_q + 5'd1;
          end
        end
        STOP_MARK: begin
          state_d = GAP;
          cnt_d   = cyc_load(GAP_CYC);
        end
        default: begin  // end of GAP
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so the registers show the current one.
    mark_d       = is_mark(state_d);
    ready_d      = (state_d == IDLE);
    frame_done_d = (state_d == GAP) && (cnt_d == '0);
  end

`ifdef NEC_IR_CARRIER_EN
  logic carr_restart;
  logic carrier;

  // Every mark starts at carrier phase 0, i.e. high on its first cycle.
  assign carr_restart = mark_d && (state_d != state_q);

  nec_ir_carrier #(
    .PERIOD_CYC (CARR_PERIOD_CYC),
    .HIGH_CYC   (CARR_HIGH_CYC)
  ) u_carrier (
    .clk25   (clk25),
    .rst     (rst),
    .restart (carr_restart),
    .enable  (mark_d),
    .carrier (carrier)
  );

  assign ir_output_d = carrier;
`else
  assign ir_output_d = mark_d;
`endif

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      ready_q      <= 1'b1;
      ir_output_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      ready_q      <= ready_d;
      ir_output_q  <= ir_output_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready      = ready_q;
  assign ir_output  = ir_output_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_nec_ir_tx.sv
`timescale 1ns/1ps
module tb_nec_ir_tx;

  // Shortened timing so a frame is a few hundred cycles. Mark lengths are chosen
  // so every mark ends on a carrier-high cycle, which lets the decoder treat any
  // zero run of at least ZS cycles as a space.
  localparam int LM = 38;
  localparam int LS = 20;
  localparam int BM = 3;
  localparam int ZS = 5;
  localparam int OS = 12;
  localparam int GP = 30;
  localparam int CP = 7;
  localparam int CH = 3;
`ifdef NEC_IR_CARRIER_EN
  localparam bit CARR = 1'b1;
`else
  localparam bit CARR = 1'b0;
`endif
  localparam int HMAX = 40000;

  logic        clk25 = 1'b0;
  logic        rst   = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] cmd   = '0;
  logic        ready, ir_output, frame_done;

  nec_ir_tx #(
    .LEAD_MARK_CYC(LM), .LEAD_SPACE_CYC(LS), .BIT_MARK_CYC(BM),
    .ZERO_SPACE_CYC(ZS), .ONE_SPACE_CYC(OS), .GAP_CYC(GP),
    .CARR_PERIOD_CYC(CP), .CARR_HIGH_CYC(CH)
  ) dut (
    .clk25(clk25), .rst(rst), .cmd(cmd), .valid(valid),
    .ready(ready), .ir_output(ir_output), .frame_done(frame_done)
  );

  always #5 clk25 = ~clk25;

  typedef struct {
    logic [31:0] c;
    int          acc;   // sample index of the accepting cycle
  } exp_t;

  exp_t exp_q[$];
  bit   exp_wave[$];
  bit   hist_ir[HMAX];
  bit   hist_rdy[HMAX];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   last_acc = 0;
  int   prev_acc = 0;
  bit   rdy_chk = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int space_len(input logic b);
    return b ? OS : ZS;
  endfunction

  function automatic int frame_len(input logic [31:0] c);
    int n;
    n = LM + LS + 33 * BM + GP;
    for (int i = 0; i < 32; i++) n += space_len(c[i]);
    return n;
  endfunction

  function automatic int bit_start(input logic [31:0] c, input int acc, input int i);
    int t;
    t = acc + 1 + LM + LS;
    for (int j = 0; j < i; j++) t += BM + space_len(c[j]);
    return t;
  endfunction

  // Reference waveform: marks are carrier (phase restarts per mark) or solid high.
  function automatic void add_seg(input bit mark, input int len);
    for (int k = 0; k < len; k++)
      exp_wave.push_back(mark && (!CARR || ((k % CP) < CH)));
  endfunction

  function automatic void build_wave(input logic [31:0] c);
    exp_wave.delete();
    add_seg(1'b1, LM);
    add_seg(1'b0, LS);
    for (int i = 0; i < 32; i++) begin
      add_seg(1'b1, BM);
      add_seg(1'b0, space_len(c[i]));
    end
    add_seg(1'b1, BM);
    add_seg(1'b0, GP);
  endfunction

  function automatic void check_frame(input exp_t e);
    int          len, bad, run, idx;
    bit          rdy_bad;
    int          runs[$];
    logic [31:0] dec;
    len     = frame_len(e.c);
    bad     = -1;
    run     = 0;
    rdy_bad = 1'b0;
    dec     = 'x;
    check("frame_done_cycle", 64'(cyc), 64'(e.acc + len));
    build_wave(e.c);
    for (int k = 0; k < len; k++) begin
      idx = e.acc + 1 + k;
      if (idx >= 0 && idx < HMAX) begin
        if (hist_ir[idx] != exp_wave[k] && bad < 0) bad = k;
        if (hist_rdy[idx]) rdy_bad = 1'b1;
        if (!hist_ir[idx]) run++;
        else begin
          if (run >= ZS) runs.push_back(run);
          run = 0;
        end
      end
    end
    if (run >= ZS) runs.push_back(run);
    check("wave_first_bad_offset_plus1", 64'(bad + 1), 64'd0);
    check("ready_high_during_frame", 64'(rdy_bad), 64'd0);
    for (int i = 0; i < 32; i++)
      if (i + 1 < runs.size()) dec[i] = (runs[i+1] >= (ZS + OS) / 2);
    check("decoded_cmd", 64'(dec), 64'(e.c));
  endfunction

  // Monitor: records outputs each cycle and checks a frame whenever frame_done shows.
  always @(negedge clk25) begin
    exp_t e;
    cyc++;
    if (cyc < HMAX) begin
      hist_ir[cyc]  = ir_output;
      hist_rdy[cyc] = ready;
    end
    if (rdy_chk) begin
      check("ready_after_frame", 64'(ready), 64'd1);
      rdy_chk = 1'b0;
    end
    if (frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("frame_done_without_cmd", 64'(frame_done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_frame(e);
        rdy_chk = 1'b1;
      end
    end
  end

  // One cycle of stimulus; the accept decision uses ready of the current cycle.
  task automatic tick(input logic v, input logic [31:0] c);
    @(negedge clk25);
    #1;
    valid = v;
    cmd   = c;
    if (v && ready === 1'b1 && !rst) begin
      exp_q.push_back('{c: c, acc: cyc});
      prev_acc = last_acc;
      last_acc = cyc;
      n_acc++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ready !== 1'b1) && n < budget) begin
      tick(1'b0, cmd);
      n++;
    end
    if (n >= budget) check("idle_timeout_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) tick(1'b0, cmd);
  endtask

  task automatic run_frame(input logic [31:0] c);
    tick(1'b1, c);
    tick(1'b0, c);
    wait_idle(3000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: stopped at cycle %0d, expected completion earlier", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] c;
    int          t0, g, n0, bad_rdy, bad_ir;

    // Reset state
    repeat (3) @(negedge clk25);
    #1;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_ir_output", 64'(ir_output), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    rst = 1'b0;
    repeat (2) tick(1'b0, '0);

    // Single reference frame
    run_frame(32'h9D620707);

    // Busy ignore: a valid pulse during a bit mark must not start a second frame
    tick(1'b1, 32'h9D620707);
    tick(1'b0, 32'h9D620707);
    t0 = bit_start(32'h9D620707, last_acc, 3);
    g = 0;
    while (cyc < t0 && g < 2000) begin tick(1'b0, 32'h9D620707); g++; end
    check("busy_ready_low", 64'(ready), 64'd0);
    tick(1'b1, 32'h9F600707);
    tick(1'b0, 32'h9F600707);
    wait_idle(3000);
    bad_rdy = 0;
    bad_ir  = 0;
    for (int i = 0; i < 700; i++) begin
      tick(1'b0, 32'h9F600707);
      if (ready !== 1'b1) bad_rdy++;
      if (ir_output !== 1'b0) bad_ir++;
    end
    check("busy_no_second_frame_ready", 64'(bad_rdy), 64'd0);
    check("busy_no_second_frame_ir", 64'(bad_ir), 64'd0);

    // Held valid: two back-to-back frames
    n0 = n_acc;
    g  = 0;
    while (n_acc < n0 + 2 && g < 3000) begin tick(1'b1, 32'h9A650707); g++; end
    tick(1'b0, 32'h9A650707);
    check("held_valid_accepts", 64'(n_acc - n0), 64'd2);
    check("back_to_back_spacing", 64'(last_acc - prev_acc), 64'(frame_len(32'h9A650707) + 1));
    wait_idle(3000);

    // Reset during bit 10, then a fresh frame
    c = $urandom();
    tick(1'b1, c);
    tick(1'b0, c);
    t0 = bit_start(c, last_acc, 10);
    g = 0;
    while (cyc < t0 && g < 2000) begin tick(1'b0, c); g++; end
    check("bit10_mark_first_cycle", 64'(ir_output), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ir_output", 64'(ir_output), 64'd0);
    check("async_rst_ready", 64'(ready), 64'd1);
    check("async_rst_frame_done", 64'(frame_done), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk25);
    #1 rst = 1'b0;
    repeat (3) tick(1'b0, c);
    run_frame($urandom());

    // Boundary and random commands
    run_frame(32'h0000_0000);
    run_frame(32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 5)) tick(1'b0, '0);
      run_frame($urandom());
    end

    repeat (5) tick(1'b0, '0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nec_ir_tx.md
Name: nec_ir_tx

Overview:
Downstream consumer of the button-to-command stage. Accepts a 32-bit NEC command word over a valid/ready handshake and serialises it as an NEC IR frame on one output pin. Output is a 38 kHz-modulated mark/space waveform driving the IR LED GPIO. The block owns all protocol timing, so the producer only presents a command and pulses valid.

Parameters:
LEAD_MARK_CYC, 225000, leader mark length in clk25 cycles (9 ms)
LEAD_SPACE_CYC, 112500, leader space length (4.5 ms)
BIT_MARK_CYC, 14063, mark before every data bit and the stop mark (562.5 us)
ZERO_SPACE_CYC, 14063, space after a 0 bit
ONE_SPACE_CYC, 42188, space after a 1 bit (1687.5 us)
GAP_CYC, 1000000, mandatory idle after the stop mark, before ready returns (40 ms)
CARR_PERIOD_CYC, 658, carrier period (about 38 kHz)
CARR_HIGH_CYC, 219, carrier high cycles per period (about 1/3 duty)

Ports:
clk25  in  1  system clock, 25 MHz
rst  in  1  reset; asynchronous, active-high
cmd  in  32  command word; cmd[0] transmitted first (address byte in [7:0], command byte in [23:16])
valid  in  1  cmd is valid this cycle
ready  out  1  block can accept a command (IDLE only)
ir_output  out  1  modulated IR drive, active-high
frame_done  out  1  one-cycle pulse on the last GAP cycle

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; duration counter, bit index, carrier counter and shift register all clear.
  - ready=1, ir_output=0, frame_done=0.
- Accept: a command is taken on a clk25 edge where valid=1 and ready=1.
  - The edge latches cmd into a shift register and moves to LEAD_MARK.
  - ready is 0 from the next cycle.
  - valid while ready=0 is ignored; no queueing. A held valid re-accepts the same cmd the cycle ready returns.
- All outputs are registered. ir_output reflects the new state starting the cycle after the accepting edge.
- State machine; each state lasts exactly its parameter count, using a down-counter loaded on entry:
  - IDLE -> LEAD_MARK on accept.
  - LEAD_MARK (LEAD_MARK_CYC) -> LEAD_SPACE (LEAD_SPACE_CYC) -> BIT_MARK.
  - BIT_MARK (BIT_MARK_CYC) -> BIT_SPACE. BIT_SPACE lasts ONE_SPACE_CYC if the current bit is 1, else ZERO_SPACE_CYC.
  - From BIT_SPACE: if bit index = 31 go to STOP_MARK, else shift right, increment index, return to BIT_MARK.
  - STOP_MARK (BIT_MARK_CYC) -> GAP (GAP_CYC) -> IDLE. frame_done is asserted on the final GAP cycle; ready=1 the following cycle.
- Mark states (LEAD_MARK, BIT_MARK, STOP_MARK): ir_output = carrier.
  - The carrier counter restarts at 0 on entry to every mark state.
  - Carrier is high while count < CARR_HIGH_CYC; the count wraps at CARR_PERIOD_CYC-1.
- Space states, GAP and IDLE: ir_output = 0.
- Durations:
  - Counter is 20 bits wide, and every parameter must be < 2^20.
  - Nominal frame length from the first mark cycle to the end of the stop mark is 9 ms + 4.5 ms + 32 bit slots + 562.5 us.
- Reset mid-frame: ir_output drops to 0 asynchronously and the frame is abandoned with no frame_done. ready is 1 after rst deasserts.

Optional Feature:
Macro NEC_IR_CARRIER_EN.
- Defined: marks are 38 kHz-modulated as above; this is the production build.
- Undefined: the carrier counter is removed and ir_output = 1 for the whole of each mark (raw envelope), for an external-modulator or logic-analyser build. All state timing is identical.

Decomposition:
- Package nec_ir_pkg holds:
  - the state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP);
  - the default cycle constants above;
  - the counter width constant (20).
- One natural sub-module, nec_ir_carrier: a restartable carrier generator with inputs restart and enable and output carrier. It is compiled out when NEC_IR_CARRIER_EN is undefined.

Test Plan:
- Reset: assert rst mid-clock -> ready=1, ir_output=0, frame_done=0 immediately, with no clock edge needed.
- Single frame: cmd=32'h9D620707, valid pulsed once -> mark/space envelope measures 225000/112500, then 32 bits LSB-first decoding back to 9D620707. 1-spaces are 42188 and 0-spaces 14063. Stop mark is 14063, then frame_done after 1000000 GAP cycles.
- Carrier: during LEAD_MARK, ir_output is high 219 / low 439 per period, starting high on the first mark cycle. With NEC_IR_CARRIER_EN undefined, ir_output is steady 1 for 225000 cycles.
- Busy ignore: pulse valid with cmd=32'h9F600707 during BIT_MARK of a frame -> the ongoing frame is unchanged and no second frame follows.
- Held valid: hold valid=1 with cmd=32'h9A650707 -> two back-to-back frames. The second LEAD_MARK starts exactly 2 cycles after the frame_done pulse.
- Reset mid-frame: assert rst during bit 10 -> ir_output=0 at once and no frame_done. A new cmd accepted after release transmits a full correct frame.
